// File: rtl/instr_loader_pkg.sv
// Shared widths for the instruction entry path and the CPU core it feeds.
// Also holds the FIFO operation encoding used by the loader's occupancy logic.
package instr_loader_pkg;

    localparam int IN_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int OPCODE_W    = 4;
    localparam int DEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        FIFO_HOLD = 2'b00,
        FIFO_PUSH = 2'b10,
        FIFO_POP  = 2'b01,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int calc_nbeats(input int instr_w, input int in_w);
        return instr_w / in_w;
    endfunction

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return FIFO_PUSH;
            2'b01:   return FIFO_POP;
            2'b11:   return FIFO_BOTH;
            default: return FIFO_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Valid/ready handshake carrying assembled instructions to the CPU core.
// The loader drives through the master modport, the core through the slave modport.
interface instr_loader_if
    import instr_loader_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) ();

    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output instr_out,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr_out,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/instr_loader_btn_conditioner.sv
// Push-button conditioning: synchroniser, debounce on the synced level, rising-edge press pulse.
// A button already held when reset releases must be let go before it can produce a press.
module btn_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press
);

    localparam int               CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   armed_q, armed_d;
    logic                   press_q, press_d;
    logic                   synced;
    logic                   flip;

    assign synced = sync_q[SYNC_STAGES-1];

    // fill_q marks when the synchroniser output reflects the pin rather than reset zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_level};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        cnt_d = '0;
        flip  = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_TC) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        stable_d = stable_q ^ flip;
        press_d  = flip & ~stable_q & armed_q;
        armed_d  = armed_q | (fill_q[SYNC_STAGES-1] & ~synced & ~stable_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/instr_loader.sv
// Assembles multi-beat switch entries into instructions and queues them for the CPU core.
// Show-ahead FIFO; head and valid come straight from registers.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int IN_W        = IN_W_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    localparam int NBEATS     = calc_nbeats(INSTR_W, IN_W),
    localparam int BEAT_W     = $clog2(NBEATS) + 1,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_level,
    input  logic [IN_W-1:0]   data_in,
    input  logic              abort,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow,
    input  logic              clr_overflow,
    instr_loader_if.master    core_if
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                press;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [INSTR_W-1:0]  asm_q, asm_d;
    logic                last_beat;
    logic                push;
    logic [INSTR_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                pop;
    logic                full;
    logic                wr_en;
    logic                drop;

    btn_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_btn (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_level (btn_level),
        .press     (press)
    );

    assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));
    assign push      = press & ~abort & last_beat;

    // On the completing beat asm_d already holds {data_in, lower beats}, so it is the pushed word
    always_comb begin
        asm_d  = asm_q;
        beat_d = beat_q;
        if (abort) begin
            asm_d  = '0;
            beat_d = '0;
        end else if (press) begin
            asm_d[int'(beat_q)*IN_W +: IN_W] = data_in;
            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            asm_q  <= '0;
        end else begin
            beat_q <= beat_d;
            asm_q  <= asm_d;
        end
    end

    assign pop  = (count_q != '0) & core_if.instr_ready;
    assign full = (count_q == CNT_W'(DEPTH));

    // A pop in the same cycle frees the slot, so a push at full is only dropped without one
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        drop     = 1'b0;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            if (!full || pop) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        case (fifo_op(wr_en, pop))
            FIFO_PUSH: count_d = count_q + 1'b1;
            FIFO_POP:  count_d = count_q - 1'b1;
            FIFO_BOTH: count_d = count_q;
            FIFO_HOLD: count_d = count_q;
            default:   count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= asm_d;
        end
    end

    assign core_if.instr_out   = mem_q[rd_ptr_q];
    assign core_if.instr_valid = (count_q != '0);
    assign beat_idx            = beat_q;
    assign fifo_count          = count_q;
    assign overflow            = ovf_q;

endmodule
